// File: rtl/dbg_reg_access.sv
// dbg_reg_access: debug-side responder giving the host read/write access to
// GPRs x0-x31, mepc, mcause, mstatus, mtvec and the (read-only) PC.
// One request at a time: halt the core, touch the register through the
// dedicated debug ports for exactly one cycle, then return a response.
// Optional build macro: DBG_STICKY_HALT_EN (halt_req stays asserted between
// requests; write to addr 63 is a resume command).
module dbg_reg_access #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [5:0]      req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            halt_req,
    input  logic            halted,
    output logic [4:0]      rf_addr,
    output logic            rf_wen,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [XLEN-1:0] rf_rdata,
    output logic [1:0]      csr_sel,
    output logic            csr_wen,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic [31:0]     pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HALT,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(HALT_TIMEOUT - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic              lat_write;
    logic [5:0]        lat_addr;
    logic [XLEN-1:0]   lat_wdata;
    logic              is_resume;
    logic              is_bad;
`ifdef DBG_STICKY_HALT_EN
    logic              resume_pend;
`endif

    // Classify the incoming request: resume command, invalid target, or real access.
    always_comb begin
        is_resume = 1'b0;
`ifdef DBG_STICKY_HALT_EN
        is_resume = req_write && (req_addr == 6'd63);
`endif
        is_bad = ((req_addr > 6'd36) && !is_resume) || (req_write && (req_addr == 6'd36));
    end

    // Request FSM; every output is a register updated on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            halt_req   <= 1'b0;
            rf_addr    <= '0;
            rf_wen     <= 1'b0;
            rf_wdata   <= '0;
            csr_sel    <= '0;
            csr_wen    <= 1'b0;
            csr_wdata  <= '0;
`ifdef DBG_STICKY_HALT_EN
            resume_pend <= 1'b0;
`endif
        end else begin
            // Write strobes are single-cycle pulses issued only in ACCESS.
            rf_wen  <= 1'b0;
            csr_wen <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (is_bad) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (is_resume) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
`ifdef DBG_STICKY_HALT_EN
                            resume_pend <= 1'b1;
`endif
                        end else begin
                            state    <= S_HALT;
                            halt_req <= 1'b1;
                            cnt      <= '0;
                        end
                    end
                end
                S_HALT: begin
                    if (halted) begin
                        state <= S_ACCESS;
                        if (lat_addr < 6'd32) begin
                            rf_addr <= lat_addr[4:0];
                            if (lat_write && (lat_addr != 6'd0)) begin
                                rf_wen   <= 1'b1;
                                rf_wdata <= lat_wdata;
                            end
                        end else begin
                            csr_sel <= lat_addr[1:0];
                            if (lat_write && (lat_addr < 6'd36)) begin
                                csr_wen   <= 1'b1;
                                csr_wdata <= lat_wdata;
                            end
                        end
                    end else if (cnt == CNT_LAST) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_ACCESS: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    if (lat_write) begin
                        resp_rdata <= '0;
                    end else if (lat_addr < 6'd32) begin
                        resp_rdata <= rf_rdata;
                    end else if (lat_addr < 6'd36) begin
                        resp_rdata <= csr_rdata;
                    end else begin
                        resp_rdata <= {{(XLEN-32){1'b0}}, pc};
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        cnt        <= '0;
`ifdef DBG_STICKY_HALT_EN
                        if (resume_pend) begin
                            halt_req    <= 1'b0;
                            resume_pend <= 1'b0;
                        end
`else
                        halt_req <= 1'b0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_reg_access.sv
// Directed self-checking bench for dbg_reg_access (default build).
module tb_dbg_reg_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [5:0]  req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        halt_req;
    logic        halted;
    logic [4:0]  rf_addr;
    logic        rf_wen;
    logic [63:0] rf_wdata;
    logic [63:0] rf_rdata;
    logic [1:0]  csr_sel;
    logic        csr_wen;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic [31:0] pc;

    int total = 0;
    int bad   = 0;

    int rf_wen_cnt   = 0;
    int csr_wen_cnt  = 0;
    int halt_cnt     = 0;
    logic [1:0]  last_csr_sel   = '0;
    logic [63:0] last_csr_wdata = '0;

    always #5 clk = ~clk;

    // Register-file / CSR models: combinational read data from the index.
    assign rf_rdata  = (rf_addr == 5'd5) ? 64'hDEAD_BEEF_0000_0001 : {59'b0, rf_addr};
    assign csr_rdata = 64'h1000 + {62'b0, csr_sel};

    dbg_reg_access #(.XLEN(64), .HALT_TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .halt_req(halt_req), .halted(halted),
        .rf_addr(rf_addr), .rf_wen(rf_wen), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .csr_sel(csr_sel), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .pc(pc)
    );

    // Strobe / halt activity monitor.
    always @(posedge clk) begin
        if (rf_wen) rf_wen_cnt++;
        if (csr_wen) begin
            csr_wen_cnt++;
            last_csr_sel   = csr_sel;
            last_csr_wdata = csr_wdata;
        end
        if (halt_req) halt_cnt++;
    end

    // Issue one request; n = negedges from the accept edge to resp_valid.
    task automatic do_req(input logic w, input logic [5:0] a, input logic [63:0] d,
                          input int halt_at, input int budget,
                          output int n, output bit expired);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        expired = 1'b1;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (resp_valid) begin
                expired = 1'b0;
                break;
            end
            if (n == halt_at) halted = 1'b1;
        end
    endtask

    task automatic ack_resp();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_err, halt_req, rf_wen, csr_wen, rf_addr, csr_sel} !== 13'b1_0000_0_00000_00) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=%b",
                     {req_ready, resp_valid, resp_err, halt_req, rf_wen, csr_wen, rf_addr, csr_sel}, 13'b1_0000_0_00000_00);
        end
        total++;
        if ({resp_rdata, rf_wdata, csr_wdata} !== 192'd0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%h want=0", resp_rdata, rf_wdata, csr_wdata);
        end
    endtask

    task automatic test_read_gpr();
        int n; bit exp; int w0;
        halted = 1'b1;
        w0 = rf_wen_cnt;
        do_req(1'b0, 6'd5, 64'h0, -1, 20, n, exp);
        total++;
        if (exp || n !== 3) begin bad++; $display("FAIL read_x5_latency got=%0d want=3 expired=%0d", n, exp); end
        total++;
        if (resp_rdata !== 64'hDEAD_BEEF_0000_0001 || resp_err !== 1'b0) begin
            bad++; $display("FAIL read_x5_data got=%h err=%b want=deadbeef00000001 err=0", resp_rdata, resp_err);
        end
        total++;
        if (halt_req !== 1'b1 || req_ready !== 1'b0) begin
            bad++; $display("FAIL read_x5_resp_ctrl got halt_req=%b req_ready=%b want 1/0", halt_req, req_ready);
        end
        ack_resp();
        total++;
        if (rf_wen_cnt - w0 !== 0) begin bad++; $display("FAIL read_x5_no_wen got=%0d want=0", rf_wen_cnt - w0); end
        total++;
        if (req_ready !== 1'b1 || halt_req !== 1'b0 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL read_x5_idle got rdy=%b halt=%b rv=%b want 1/0/0", req_ready, halt_req, resp_valid);
        end
    endtask

    task automatic test_write_csr();
        int n; bit exp; int c0;
        halted = 1'b0;
        c0 = csr_wen_cnt;
        do_req(1'b1, 6'd34, 64'h1800, 10, 40, n, exp);
        total++;
        if (exp || n !== 12) begin bad++; $display("FAIL wr_mstatus_latency got=%0d want=12 expired=%0d", n, exp); end
        total++;
        if (csr_wen_cnt - c0 !== 1) begin bad++; $display("FAIL wr_mstatus_pulses got=%0d want=1", csr_wen_cnt - c0); end
        total++;
        if (last_csr_sel !== 2'd2 || last_csr_wdata !== 64'h1800) begin
            bad++; $display("FAIL wr_mstatus_port got sel=%0d wdata=%h want sel=2 wdata=1800", last_csr_sel, last_csr_wdata);
        end
        total++;
        if (resp_err !== 1'b0 || resp_rdata !== 64'h0) begin
            bad++; $display("FAIL wr_mstatus_resp got err=%b rdata=%h want 0/0", resp_err, resp_rdata);
        end
        ack_resp();
    endtask

    task automatic test_timeout();
        int n; bit exp; int w0, c0;
        halted = 1'b0;
        w0 = rf_wen_cnt; c0 = csr_wen_cnt;
        do_req(1'b1, 6'd7, 64'h55, -1, 400, n, exp);
        total++;
        if (exp || n !== 256) begin bad++; $display("FAIL timeout_cycles got=%0d want=256 expired=%0d", n, exp); end
        total++;
        if (resp_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", resp_err); end
        ack_resp();
        total++;
        if (halt_req !== 1'b0) begin bad++; $display("FAIL timeout_halt_drop got=%b want=0", halt_req); end
        total++;
        if ((rf_wen_cnt - w0) + (csr_wen_cnt - c0) !== 0) begin
            bad++; $display("FAIL timeout_no_strobe got=%0d want=0", (rf_wen_cnt - w0) + (csr_wen_cnt - c0));
        end
    endtask

    task automatic test_invalid();
        int n; bit exp; int h0;
        halted = 1'b1;
        h0 = halt_cnt;
        do_req(1'b1, 6'd36, 64'h1234, -1, 20, n, exp);
        total++;
        if (exp || n !== 1 || resp_err !== 1'b1) begin
            bad++; $display("FAIL wr_pc_err got n=%0d err=%b want n=1 err=1", n, resp_err);
        end
        ack_resp();
        do_req(1'b0, 6'd40, 64'h0, -1, 20, n, exp);
        total++;
        if (exp || n !== 1 || resp_err !== 1'b1 || resp_rdata !== 64'h0) begin
            bad++; $display("FAIL rd_40_err got n=%0d err=%b rdata=%h want n=1 err=1 rdata=0", n, resp_err, resp_rdata);
        end
        ack_resp();
        do_req(1'b1, 6'd63, 64'h0, -1, 20, n, exp);
        total++;
        if (exp || n !== 1 || resp_err !== 1'b1) begin
            bad++; $display("FAIL wr_63_err got n=%0d err=%b want n=1 err=1", n, resp_err);
        end
        ack_resp();
        total++;
        if (halt_cnt - h0 !== 0) begin bad++; $display("FAIL invalid_no_halt got=%0d want=0", halt_cnt - h0); end
    endtask

    task automatic test_x0_pc();
        int n; bit exp; int w0;
        halted = 1'b1;
        w0 = rf_wen_cnt;
        do_req(1'b1, 6'd0, 64'hFFFF, -1, 20, n, exp);
        total++;
        if (exp || n !== 3 || resp_err !== 1'b0) begin
            bad++; $display("FAIL wr_x0_resp got n=%0d err=%b want n=3 err=0", n, resp_err);
        end
        ack_resp();
        total++;
        if (rf_wen_cnt - w0 !== 0) begin bad++; $display("FAIL wr_x0_no_wen got=%0d want=0", rf_wen_cnt - w0); end
        do_req(1'b1, 6'd9, 64'hABCD, -1, 20, n, exp);
        total++;
        if (rf_wen_cnt - w0 !== 1 || rf_wdata !== 64'hABCD || rf_addr !== 5'd9) begin
            bad++; $display("FAIL wr_x9 got pulses=%0d wdata=%h addr=%0d want 1/abcd/9", rf_wen_cnt - w0, rf_wdata, rf_addr);
        end
        ack_resp();
        pc = 32'h8000_0004;
        do_req(1'b0, 6'd36, 64'h0, -1, 20, n, exp);
        total++;
        if (exp || resp_rdata !== 64'h0000_0000_8000_0004 || resp_err !== 1'b0) begin
            bad++; $display("FAIL rd_pc got=%h err=%b want=0000000080000004 err=0", resp_rdata, resp_err);
        end
        ack_resp();
    endtask

    task automatic test_hold_reset();
        int n; bit exp; int bad_hold;
        halted = 1'b1;
        do_req(1'b0, 6'd33, 64'h0, -1, 20, n, exp);
        bad_hold = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== 64'h1001 || resp_err !== 1'b0) bad_hold++;
        end
        total++;
        if (exp || bad_hold !== 0) begin
            bad++; $display("FAIL resp_hold got bad_cycles=%0d rdata=%h want 0 and 1001", bad_hold, resp_rdata);
        end
        ack_resp();
        halted = 1'b0;
        do_req(1'b0, 6'd3, 64'h0, -1, 3, n, exp);
        total++;
        if (halt_req !== 1'b1 || req_ready !== 1'b0) begin
            bad++; $display("FAIL mid_halt got halt_req=%b req_ready=%b want 1/0", halt_req, req_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, resp_valid, resp_err, halt_req, rf_wen, csr_wen} !== 6'b100000 || resp_rdata !== 64'h0) begin
            bad++; $display("FAIL async_reset got=%b rdata=%h want=100000 rdata=0",
                            {req_ready, resp_valid, resp_err, halt_req, rf_wen, csr_wen}, resp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        halted = 1'b1;
        bad_hold = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || halt_req !== 1'b0) bad_hold++;
        end
        total++;
        if (bad_hold !== 0) begin bad++; $display("FAIL post_reset_idle got bad_cycles=%0d want=0", bad_hold); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; halted = 1'b0; pc = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_reset();
        test_read_gpr();
        test_write_csr();
        test_timeout();
        test_invalid();
        test_x0_pc();
        test_hold_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbg_reg_access.md
Name: dbg_reg_access

Overview:
- Debug-side responder giving the simulation host read/write access to core architectural state: GPRs x0-x31, mepc, mcause, mstatus, mtvec, and PC (read-only).
- The host side issues one request at a time over a valid/ready channel.
- The block halts the core at an instruction boundary, performs the access through dedicated register-file and CSR debug ports, and returns a response.
- It is the write/command direction that complements the existing state-export path to the simulator.

Parameters:
- XLEN, 64, data width of GPRs, CSRs and the request/response data.
- HALT_TIMEOUT, 255, maximum cycles spent waiting for halted before the request fails; 8-bit counter, range 1-255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  host request valid.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  6  target: 0-31 GPR; 32 mepc; 33 mcause; 34 mstatus; 35 mtvec; 36 pc; 37-63 invalid.
- req_wdata  in  XLEN  write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  host accepts response.
- resp_rdata  out  XLEN  read data; 0 for writes and errors.
- resp_err  out  1  request failed.
- halt_req  out  1  request that the core stop at the next instruction boundary.
- halted  in  1  core is stopped.
- rf_addr  out  5  GPR debug port index.
- rf_wen  out  1  GPR debug write strobe.
- rf_wdata  out  XLEN  GPR debug write data.
- rf_rdata  in  XLEN  GPR debug read data; combinational from rf_addr.
- csr_sel  out  2  0 mepc, 1 mcause, 2 mstatus, 3 mtvec.
- csr_wen  out  1  CSR debug write strobe.
- csr_wdata  out  XLEN  CSR debug write data.
- csr_rdata  in  XLEN  CSR debug read data; combinational from csr_sel.
- pc  in  32  current PC; zero-extended on read.

Behaviour:
- Reset: async on rst_n low.
  - State goes to IDLE; timeout counter cleared; request latches cleared.
  - All outputs are 0, except req_ready, which is 1 after reset in IDLE.
  - Reset in any state abandons the request; no response is produced.
- FSM states are IDLE, HALT, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch write, addr and wdata.
  - If addr > 36, or write with addr == 36: go to RESP with err = 1 and no halt.
  - Otherwise go to HALT.
- HALT:
  - halt_req = 1; the counter increments each cycle.
  - If halted = 1, go to ACCESS next cycle.
  - If the counter reaches HALT_TIMEOUT with halted = 0, go to RESP with err = 1.
- ACCESS (exactly one cycle):
  - Drive rf_addr = addr[4:0] or csr_sel = addr - 32.
  - Write:
    - Pulse rf_wen or csr_wen for this single cycle with the wdata.
    - A write to x0 produces no strobe and err = 0.
  - Read: capture rf_rdata, csr_rdata or {32'b0, pc} at the end of the cycle.
  - Go to RESP.
- RESP:
  - resp_valid = 1; rdata and err are held stable until resp_ready.
  - On handshake, return to IDLE and clear the counter.
  - halt_req deasserts on entry to IDLE.
- Latency, with the core already halted: request accepted at cycle T; HALT at T+1; ACCESS at T+2; resp_valid at T+3.
- halt_req stays asserted through ACCESS and RESP, so the core cannot resume between access and response.
- No new request is accepted while resp_valid is high; req_ready = 0 outside IDLE.
- Write strobes are never asserted unless halted was observed as 1.

Optional Feature:
- DBG_STICKY_HALT_EN defined:
  - halt_req remains 1 after the RESP handshake, so back-to-back requests skip the halt wait.
  - A request with addr 63 and req_write = 1 is a resume command: go to RESP with err = 0, then drop halt_req on return to IDLE.
  - Other invalid addresses still return err.
- Undefined: halt_req drops after every response, and addr 63 is an error.

Test Plan:
- Core already halted, read x5 with rf_rdata = 64'hDEAD_BEEF_0000_0001 -> resp_valid at T+3, rdata matches, err = 0; rf_wen never asserted.
- Write mstatus = 64'h1800 with halted rising 10 cycles after the request -> exactly one csr_wen pulse with csr_sel = 2 and wdata 0x1800; then a response with err = 0.
- halted held 0, HALT_TIMEOUT = 255 -> err = 1 after 255 HALT cycles; halt_req drops; no write strobe.
- Write to pc (addr 36) and read addr 40 -> immediate error responses; halt_req never asserted.
- Write x0 -> no rf_wen, err = 0; read pc = 32'h8000_0004 -> rdata = 64'h0000_0000_8000_0004.
- resp_ready held low for 5 cycles, then rst_n pulsed low mid-HALT on a second request -> response held stable; after reset, all outputs at reset values and req_ready = 1.
